// File: rtl/ac97_pcm_fifo_if.sv
// Producer-side valid/ready handshake carrying one stereo PCM pair per transfer.
interface ac97_pcm_fifo_if #(
    parameter int SAMPLE_W = 20
);
    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_left;
    logic [SAMPLE_W-1:0] in_right;

    modport master (output in_valid, output in_left, output in_right, input in_ready);
    modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/ac97_pcm_fifo.sv
// Stereo PCM FIFO feeding AC-link slots 3/4: one pair popped per frame strobe,
// held for the whole frame, with a saturating underrun counter.
module ac97_pcm_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int SAMPLE_W   = 20
) (
    input  logic                  ac97_bitclk,
    input  logic                  ac97_rst_b,
    input  logic                  ac97_strobe,
    input  logic                  pcm_enable,
    input  logic                  pcm_flush,
    ac97_pcm_fifo_if.slave        in_if,
    output logic [SAMPLE_W-1:0]   ac97_out_slot3,
    output logic                  ac97_out_slot3_valid,
    output logic [SAMPLE_W-1:0]   ac97_out_slot4,
    output logic                  ac97_out_slot4_valid,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [15:0]           underrun_count
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [2*SAMPLE_W-1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wptr, r_rptr;
    logic [DEPTH_LOG2:0]     r_level;
    logic [SAMPLE_W-1:0]     r_slot3, r_slot4;
    logic                    r_slot_vld;
    logic [15:0]             r_underrun;

    logic w_ready, w_push, w_pop, w_starve;

    // Ready depends only on registered state and flush, never on in_valid.
    assign w_ready  = (r_level != LVL_FULL) && !pcm_flush;
    assign w_push   = in_if.in_valid && w_ready;
    // Flush beats a coincident strobe: the frame is treated as starved.
    assign w_pop    = ac97_strobe && pcm_enable && (r_level != '0) && !pcm_flush;
    assign w_starve = ac97_strobe && pcm_enable && !w_pop;

    assign in_if.in_ready       = w_ready;
    assign ac97_out_slot3       = r_slot3;
    assign ac97_out_slot4       = r_slot4;
    assign ac97_out_slot3_valid = r_slot_vld;
    assign ac97_out_slot4_valid = r_slot_vld;
    assign fifo_level           = r_level;
    assign underrun_count       = r_underrun;

    always_ff @(posedge ac97_bitclk) begin
        if (w_push) r_mem[r_wptr] <= {in_if.in_left, in_if.in_right};
    end

    always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
        if (!ac97_rst_b) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (pcm_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
            else if (w_pop && !w_push) r_level <= r_level - LVL_ONE;
        end
    end

    // Slot registers move only on strobe edges so the link sees a stable frame.
    always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
        if (!ac97_rst_b) begin
            r_slot3    <= '0;
            r_slot4    <= '0;
            r_slot_vld <= 1'b0;
            r_underrun <= '0;
        end else if (ac97_strobe) begin
            if (w_pop) begin
                r_slot3    <= r_mem[r_rptr][2*SAMPLE_W-1:SAMPLE_W];
                r_slot4    <= r_mem[r_rptr][SAMPLE_W-1:0];
                r_slot_vld <= 1'b1;
            end else begin
                r_slot3    <= '0;
                r_slot4    <= '0;
                r_slot_vld <= 1'b0;
            end
            if (w_starve && (r_underrun != 16'hFFFF)) r_underrun <= r_underrun + 16'd1;
        end
    end
endmodule

// File: tb/tb_ac97_pcm_fifo.sv
// Directed bench for ac97_pcm_fifo: fill/drain, full, underrun, enable, flush, reset.
module tb_ac97_pcm_fifo;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        strobe = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [19:0] slot3, slot4;
    logic        slot3_vld, slot4_vld;
    logic [4:0]  level;
    logic [15:0] urun;
    int          checks = 0;
    int          errors = 0;
    int          acc;

    ac97_pcm_fifo_if #(.SAMPLE_W(20)) pif ();

    ac97_pcm_fifo #(.DEPTH_LOG2(4), .SAMPLE_W(20)) dut (
        .ac97_bitclk          (clk),
        .ac97_rst_b           (rst_b),
        .ac97_strobe          (strobe),
        .pcm_enable           (enable),
        .pcm_flush            (flush),
        .in_if                (pif),
        .ac97_out_slot3       (slot3),
        .ac97_out_slot3_valid (slot3_vld),
        .ac97_out_slot4       (slot4),
        .ac97_out_slot4_valid (slot4_vld),
        .fifo_level           (level),
        .underrun_count       (urun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_strobe();
        strobe = 1'b1;
        cyc(1);
        strobe = 1'b0;
    endtask

    task automatic push(input logic [19:0] l, input logic [19:0] r);
        pif.in_valid = 1'b1;
        pif.in_left  = l;
        pif.in_right = r;
        cyc(1);
        pif.in_valid = 1'b0;
    endtask

    task automatic chk_slots(input string tag, input logic [19:0] l, input logic [19:0] r, input logic v);
        chk({tag, "_l"}, 32'(slot3), 32'(l));
        chk({tag, "_r"}, 32'(slot4), 32'(r));
        chk({tag, "_v3"}, 32'(slot3_vld), 32'(v));
        chk({tag, "_v4"}, 32'(slot4_vld), 32'(v));
    endtask

    initial begin
        pif.in_valid = 1'b0;
        pif.in_left  = '0;
        pif.in_right = '0;
        cyc(3);
        chk_slots("rst", 20'h0, 20'h0, 1'b0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_urun", 32'(urun), 32'd0);
        rst_b = 1'b1;
        cyc(1);
        chk("rst_ready", 32'(pif.in_ready), 32'd1);

        // Three pairs out over three frames, then a starved frame.
        enable = 1'b1;
        push(20'h00001, 20'h7FFFF);
        push(20'h00002, 20'h80000);
        push(20'h00003, 20'h12345);
        chk("fill3_level", 32'(level), 32'd3);
        frame_strobe();
        chk_slots("f1", 20'h00001, 20'h7FFFF, 1'b1);
        chk("f1_level", 32'(level), 32'd2);
        cyc(255);
        chk_slots("f1_hold", 20'h00001, 20'h7FFFF, 1'b1);
        frame_strobe();
        chk_slots("f2", 20'h00002, 20'h80000, 1'b1);
        chk("f2_level", 32'(level), 32'd1);
        cyc(255);
        frame_strobe();
        chk_slots("f3", 20'h00003, 20'h12345, 1'b1);
        chk("f3_level", 32'(level), 32'd0);
        cyc(255);
        frame_strobe();
        chk_slots("f4", 20'h0, 20'h0, 1'b0);
        chk("f4_urun", 32'(urun), 32'd1);

        // Continuous in_valid with no strobes: exactly 16 accepted.
        acc = 0;
        pif.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pif.in_left  = 20'h00100 + 20'(acc);
            pif.in_right = 20'h00200 + 20'(acc);
            if (pif.in_ready) acc++;
            cyc(1);
        end
        chk("full_acc", 32'(acc), 32'd16);
        chk("full_level", 32'(level), 32'd16);
        chk("full_ready", 32'(pif.in_ready), 32'd0);
        pif.in_left  = 20'h00EEE;
        pif.in_right = 20'h00FFF;
        frame_strobe();
        chk("pop_full_level", 32'(level), 32'd15);
        chk("pop_full_ready", 32'(pif.in_ready), 32'd1);
        chk_slots("pop_full", 20'h00100, 20'h00200, 1'b1);
        cyc(1);
        pif.in_valid = 1'b0;
        chk("refill_level", 32'(level), 32'd16);
        chk("refill_ready", 32'(pif.in_ready), 32'd0);
        flush = 1'b1;
        chk("flush_ready", 32'(pif.in_ready), 32'd0);
        cyc(1);
        flush = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_urun", 32'(urun), 32'd1);
        chk_slots("flush_hold", 20'h00100, 20'h00200, 1'b1);

        // Push on the same edge as a strobe at level 0: underrun, no bypass.
        strobe = 1'b1;
        push(20'hAAAAA, 20'h55555);
        strobe = 1'b0;
        chk("pstb_urun", 32'(urun), 32'd2);
        chk("pstb_level", 32'(level), 32'd1);
        chk_slots("pstb", 20'h0, 20'h0, 1'b0);
        cyc(255);
        frame_strobe();
        chk_slots("pstb_next", 20'hAAAAA, 20'h55555, 1'b1);
        chk("pstb_next_level", 32'(level), 32'd0);

        // Playback disabled with data waiting.
        for (int i = 0; i < 5; i++) push(20'h01000 + 20'(i), 20'h02000 + 20'(i));
        enable = 1'b0;
        for (int f = 0; f < 4; f++) begin
            cyc(50);
            frame_strobe();
            chk_slots("dis", 20'h0, 20'h0, 1'b0);
            chk("dis_level", 32'(level), 32'd5);
        end
        chk("dis_urun", 32'(urun), 32'd2);

        // Flush coinciding with a strobe at level 7.
        push(20'h01005, 20'h02005);
        push(20'h01006, 20'h02006);
        chk("pre_fs_level", 32'(level), 32'd7);
        enable = 1'b1;
        frame_strobe();
        chk_slots("f_after_dis", 20'h01000, 20'h02000, 1'b1);
        chk("f_after_dis_level", 32'(level), 32'd6);
        push(20'h01007, 20'h02007);
        flush  = 1'b1;
        strobe = 1'b1;
        cyc(1);
        flush  = 1'b0;
        strobe = 1'b0;
        chk("fs_level", 32'(level), 32'd0);
        chk_slots("fs", 20'h0, 20'h0, 1'b0);
        chk("fs_urun", 32'(urun), 32'd3);

        // Saturation of the underrun counter.
        force dut.r_underrun = 16'hFFFF;
        cyc(1);
        release dut.r_underrun;
        cyc(1);
        chk("sat_pre", 32'(urun), 32'hFFFF);
        frame_strobe();
        chk("sat_post", 32'(urun), 32'hFFFF);

        // Reset mid-frame while slots hold valid data.
        push(20'h0BEEF, 20'h0CAFE);
        push(20'h0DEAD, 20'h0F00D);
        frame_strobe();
        chk_slots("pre_rst", 20'h0BEEF, 20'h0CAFE, 1'b1);
        cyc(50);
        #2;
        rst_b = 1'b0;
        #1;
        chk_slots("mid_rst", 20'h0, 20'h0, 1'b0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_urun", 32'(urun), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        cyc(1);
        chk("post_rst_ready", 32'(pif.in_ready), 32'd1);
        chk("post_rst_level", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ac97_pcm_fifo.md
# ac97_pcm_fifo

Per-frame PCM sample buffer that sits directly upstream of the AC-link serializer. It accepts stereo 20-bit sample pairs from any producer through a valid/ready handshake. On each frame strobe from the link it pops one pair and presents it as slot-3 (left) and slot-4 (right) data plus valid flags, stable for the whole 256-bit frame. It replaces the free-running test-tone source feeding slots 3/4 and reports underruns.

## Interface
Parameters:
- DEPTH_LOG2, default 4: FIFO holds 2^DEPTH_LOG2 stereo pairs (16).
- SAMPLE_W, default 20: sample width, equal to the AC-link slot width.

Ports (name, direction, width, meaning):
- ac97_bitclk, input, 1: the only clock, codec bit clock, rising edge.
- ac97_rst_b, input, 1: reset, asynchronous and active-low.
- ac97_strobe, input, 1: one-cycle frame strobe from the link, high once per 256 cycles.
- pcm_enable, input, 1: playback enable, sampled only on strobe cycles.
- pcm_flush, input, 1: synchronous FIFO clear.
- in_valid, input, 1: producer offers a pair.
- in_ready, output, 1: FIFO can accept a pair.
- in_left, input, SAMPLE_W: left sample, two's complement.
- in_right, input, SAMPLE_W: right sample, two's complement.
- ac97_out_slot3, output, SAMPLE_W: left sample to the link.
- ac97_out_slot3_valid, output, 1: slot-3 tag bit.
- ac97_out_slot4, output, SAMPLE_W: right sample to the link.
- ac97_out_slot4_valid, output, 1: slot-4 tag bit.
- fifo_level, output, DEPTH_LOG2+1: pairs currently stored, 0..16.
- underrun_count, output, 16: saturating count of frames starved while enabled.

## Operation
- Storage: 2^DEPTH_LOG2 entries of {left, right} in a register array. Write and read pointers are DEPTH_LOG2 bits and wrap modulo depth. The occupancy counter is DEPTH_LOG2+1 bits.
- Push: in_valid && in_ready on a rising edge writes the pair at the write pointer and increments the pointer.
- in_ready = (fifo_level != 2^DEPTH_LOG2) && !pcm_flush. It is combinational from registered state only and never depends on in_valid.
- Pop decision, evaluated only in cycles where ac97_strobe=1:
  - pcm_enable=1 and level>0: read the entry at the read pointer into the slot output registers, set both valid flags to 1, advance the read pointer.
  - pcm_enable=1 and level=0 (underrun): slot data registers become 0, valid flags become 0, underrun_count increments, saturating at 0xFFFF.
  - pcm_enable=0: slot data 0, valid flags 0, no pop, no count.
- Slot outputs change only on strobe cycles and are otherwise held.
- Simultaneous push and pop: both take effect and the level is unchanged.
- Push into a full FIFO during a strobe pop is refused, because in_ready was already low. The pair is accepted on the next cycle.
- Push into an empty FIFO on a strobe cycle: the strobe sees level=0 and records an underrun; the pushed pair is stored for the next frame. There is no bypass path.
- pcm_flush=1: read and write pointers and the level go to 0, and any push that cycle is ignored. Slot outputs and underrun_count are unaffected. If flush and strobe coincide, flush wins for the FIFO and the strobe behaves as an underrun (the count increments if enabled).
- Slot-3 and slot-4 valid flags are always equal.

## Timing
- Reset (ac97_rst_b=0, takes effect immediately): pointers 0, fifo_level 0, in_ready 1 after release, all slot data 0, both valid flags 0, underrun_count 0. Memory contents are don't-care.
- A reset asserted mid-frame clears the slot outputs at once. The link then transmits zero/invalid for the rest of that frame.
- Push-to-level latency: 1 cycle (fifo_level updates on the accepting edge).
- Pop latency: slot outputs are valid on the edge where ac97_strobe=1, so the link sees new data from the first slot bit onward and it is stable for 256 cycles.
- Minimum fill-to-output: a pair accepted at edge N reaches the slots at the first strobe edge strictly after N.
- Throughput: one push per cycle; one pop per frame.

## Test plan
- Reset, then push 3 pairs (L=0x00001/R=0x7FFFF, 0x00002/0x80000, 0x00003/0x12345) with pcm_enable=1 and strobe every 256 cycles -> three successive frames present those pairs with valid=1, the 4th frame gives valid=0 and data 0, underrun_count=1, fifo_level goes 3,2,1,0.
- Hold in_valid high continuously with no strobes -> exactly 16 pairs accepted, in_ready low at level 16. After one strobe, level 15 and in_ready high for one accept.
- Push on the same edge as a strobe with level 0 -> underrun_count increments, level becomes 1, and the next strobe outputs that pair.
- pcm_enable=0 with level 5 across 4 strobes -> valid=0 each frame, level stays 5, underrun_count unchanged.
- pcm_flush coinciding with a strobe at level 7 and enable=1 -> level 0, slots invalid, underrun_count +1. Force the count to 0xFFFF and starve one more frame -> it stays 0xFFFF.
- Assert ac97_rst_b low for 1 cycle mid-frame while slots hold valid data -> outputs 0/invalid immediately, level 0, in_ready=1 after release.
